// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and the serializer state encoding.
package mmio_pkg;

    localparam logic [2:0] OFF_TXDATA = 3'h0;
    localparam logic [2:0] OFF_STATUS = 3'h4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_BUSY  = 3;
    localparam int ST_CNT   = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO; a push while full or a pop while empty is ignored.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-responder UART transmitter: stores to TXDATA queue bytes that are sent
// as 8N1 frames on Tx; STATUS is readable combinationally.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h80,
    parameter int          DEPTH        = 4,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        Tx
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_t   state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n, head;
    logic          tx_n, pop, baud_end;
    logic          full, empty, ovf;
    logic [CW-1:0] cnt;
    logic          is_status, wr_tx, wr_st;
    logic [31:0]   status;
    logic          unused_bits;

    assign unused_bits = ^{DataAdr[1:0], WriteData[31:8]};

    // Only address bit 2 picks the register; the low byte-lane bits are don't-care.
    assign Sel       = (DataAdr[31:3] == BASE_ADDR[31:3]);
    assign is_status = (DataAdr[2] == OFF_STATUS[2]);
    assign wr_tx     = MemWrite && Sel && (DataAdr[2] == OFF_TXDATA[2]);
    assign wr_st     = MemWrite && Sel && is_status;

    fifo_sync #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .din   (WriteData[7:0]),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (cnt)
    );

    // Setting wins over a same-edge clear so a dropped byte is never missed.
    always_ff @(posedge clk) begin
        if (reset)                                ovf <= 1'b0;
        else if (wr_tx && full)                   ovf <= 1'b1;
        else if (wr_st && WriteData[ST_OVF])      ovf <= 1'b0;
    end

    always_comb begin
        status                 = '0;
        status[ST_FULL]        = full;
        status[ST_EMPTY]       = empty;
        status[ST_OVF]         = ovf;
        status[ST_BUSY]        = (state != IDLE) || !empty;
        status[ST_CNT +: 4]    = 4'(cnt);
        ReadData               = (Sel && is_status) ? status : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            Tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            Tx      <= tx_n;
        end
    end

    assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else baud_n = baud + 1'b1;
            end
            DATA: begin
                if (baud_end) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end else baud_n = baud + 1'b1;
            end
            STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = START;
                    end else state_n = IDLE;
                end else baud_n = baud + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // Tx is registered, so it is derived from where the FSM is heading.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench: a line monitor decodes frames on Tx and compares them
// against a queue of expected bytes filled as stores are issued.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, MemWrite, Sel, Tx;
    logic [31:0] DataAdr, WriteData, ReadData;

    int         n_chk = 0, n_pass = 0, cyc = 0, frames_done = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int         fs[$];

    mmio_uart_tx #(.BASE_ADDR(32'h80), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Sel       (Sel),
        .Tx        (Tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic store(logic [31:0] a, logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic rd(logic [31:0] a, output logic [31:0] d, output logic s);
        DataAdr = a;
        #1;
        d = ReadData;
        s = Sel;
    endtask

    task automatic wait_frames(int n);
        int t = 0;
        while (frames_done < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("frames_done", frames_done, n);
    endtask

    // Line monitor: samples each bit in its middle, offsets counted from the
    // first low cycle of the start bit.
    initial begin
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev === 1'b1 && Tx === 1'b0) begin
                fs.push_back(cyc);
                repeat (CPB/2) @(negedge clk);
                check("start_bit", Tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = Tx;
                end
                repeat (CPB) @(negedge clk);
                check("stop_bit", Tx, 1);
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("frame_byte", b, exp_q.pop_front());
                frames_done++;
                repeat (CPB/2 - 1) @(negedge clk);
            end
            prev = Tx;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        s;
        logic        saw_low;
        reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        repeat (2) @(negedge clk);
        check("reset_tx", Tx, 1);
        rd(32'h84, d, s); check("reset_status", d, 32'h2);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single frame with latency and end-of-frame boundary.
        exp_q.push_back(8'h55);
        store(32'h80, 32'hFFFF_FF55);
        check("tx_idle_cycle_k", Tx, 1);
        rd(32'h84, d, s); check("status_after_store", d, 32'h18);
        @(negedge clk);
        check("tx_start_k1", Tx, 0);
        repeat (39) @(negedge clk);
        rd(32'h84, d, s); check("status_in_stop", d, 32'h0A);
        @(negedge clk);
        rd(32'h84, d, s); check("status_idle_41", d, 32'h2);
        wait_frames(1);

        // Back-to-back frames.
        exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        store(32'h80, 32'h41);
        store(32'h80, 32'h42);
        rd(32'h84, d, s); check("b2b_count_early", d, 32'h18);
        repeat (20) @(negedge clk);
        rd(32'h84, d, s); check("b2b_count_mid", d, 32'h18);
        wait_frames(3);
        check("b2b_gap", fs[2] - fs[1], 10*CPB);
        repeat (3) @(negedge clk);
        rd(32'h84, d, s); check("b2b_idle", d, 32'h2);

        // Overflow: six consecutive stores, the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'(8'h10 + i));
            store(32'h80, 32'h10 + i);
        end
        rd(32'h84, d, s); check("ovf_status", d, 32'h4D);
        store(32'h84, 32'hFB);
        rd(32'h84, d, s); check("ovf_kept", d, 32'h4D);
        store(32'h84, 32'h4);
        rd(32'h84, d, s); check("ovf_cleared", d, 32'h49);
        wait_frames(8);
        for (int j = 4; j < 8; j++) check("ovf_gap", fs[j] - fs[j-1], 10*CPB);
        repeat (3) @(negedge clk);
        rd(32'h84, d, s); check("ovf_idle", d, 32'h2);
        check("queue_drained", exp_q.size(), 0);

        // Address decode.
        store(32'h88, 32'h99);
        rd(32'h88, d, s); check("dec_88_sel", s, 0); check("dec_88_rd", d, 0);
        rd(32'h7C, d, s); check("dec_7c_sel", s, 0); check("dec_7c_rd", d, 0);
        rd(32'h80, d, s); check("dec_80_sel", s, 1); check("dec_80_rd", d, 0);
        rd(32'h87, d, s); check("dec_87_status", d, 32'h2);

        // Reset in the middle of data bit 3.
        mon_en = 1'b0;
        store(32'h80, 32'h33);
        store(32'h80, 32'h44);
        repeat (17) @(negedge clk);
        check("mid_bit3", Tx, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_tx", Tx, 1);
        rd(32'h84, d, s); check("rst_mid_status", d, 32'h2);
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (Tx !== 1'b1) saw_low = 1'b1;
        end
        check("rst_no_frame", saw_low, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the processor's data-memory bus as a responder, beside `dmem`. It decodes `MemWrite`/`DataAdr`/`WriteData` from the core. Stored bytes are queued in a small FIFO and serialized as 8N1 frames on `Tx`. A status word is returned combinationally for loads. The core cannot stall, so writes to a full FIFO are dropped and flagged.

## Interface
- `BASE_ADDR`, default 32'h80: byte address of the register pair; must be 8-byte aligned.
- `DEPTH`, default 4: FIFO entries; power of two, 2..8.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; ≥2.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemWrite`  in  1  store strobe from core.
- `DataAdr`  in  32  byte address from core.
- `WriteData`  in  32  store data from core.
- `ReadData`  out  32  load data, valid when `Sel`=1.
- `Sel`  out  1  address hit: `DataAdr[31:3] == BASE_ADDR[31:3]`; top-level read mux uses it.
- `Tx`  out  1  serial line, registered, idle high.

## Operation
- **TXDATA register, BASE+0.**
  - Store: enqueue `WriteData[7:0]` if FIFO not full; upper bits ignored.
  - Load: returns 0.
- **STATUS register, BASE+4.** Load returns:
  - [0] full
  - [1] empty
  - [2] overflow (sticky)
  - [3] busy (FSM not IDLE or FIFO non-empty)
  - [7:4] count
  - [31:8] zero
- **STATUS store.** Writing with `WriteData[2]`=1 clears overflow. Other bits are ignored.
- **Full-FIFO store.** A store to TXDATA when full (registered full flag, sampled before any same-cycle pop) discards the byte and sets overflow.
- **Unmapped addresses.**
  - `Sel`=1 with `DataAdr[1:0]`≠0 is decoded by `DataAdr[2]` only.
  - Stores with `Sel`=0 are ignored.
- **`ReadData` is combinational** from `DataAdr` and registered state, and is 0 when `Sel`=0.
- **FSM states:** IDLE, START, DATA, STOP. Each state holds a baud counter running 0..CLKS_PER_BIT-1 and a bit index 0..7.
  - **IDLE:** `Tx`=1. If FIFO non-empty: pop head into the shifter, go to START.
  - **START:** `Tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - **DATA:** `Tx`=shifter[0], LSB first; shift every CLKS_PER_BIT cycles; after bit 7 go to STOP.
  - **STOP:** `Tx`=1 for CLKS_PER_BIT cycles. Then, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- **Count arithmetic.**
  - Count has width clog2(DEPTH)+1.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Count never exceeds DEPTH and never underflows; pop only when non-empty.

## Timing
- **Reset** (sampled high on a rising edge):
  - FIFO empty, overflow 0, state IDLE, counters 0, `Tx`=1 from that edge.
  - Reset mid-frame aborts the frame and discards queued bytes.
- **Store commit.** A store commits on the rising edge ending the cycle in which `MemWrite`=1 (edge k). STATUS reads reflect it in cycle k.
- **Start latency.** With the FIFO empty and the FSM in IDLE:
  - The pop occurs at edge k+1.
  - `Tx` is low from edge k+1 for CLKS_PER_BIT cycles.
- **Frame length.** Exactly 10·CLKS_PER_BIT cycles from the falling start edge to the end of stop.
- **Back-to-back frames.** Queued bytes produce contiguous frames with no gap.
- **Sticky overflow.** If a clear and an overflow happen on the same edge, overflow stays set.

## Structure
- **Package `mmio_pkg`** holds:
  - TXDATA/STATUS offsets
  - STATUS bit positions
  - FSM state enum `uart_state_t`
- **Sub-module `fifo_sync`** (parameters WIDTH, DEPTH):
  - push/pop, full/empty/count outputs.
  - Ignores push when full and pop when empty.
- **Top level** instantiates `mmio_uart_tx` next to `dmem`. `ReadData` to the core is `Sel ? uart ReadData : dmem rd`. `dmem`'s write enable is gated with `~Sel`.

## Test plan
- **Reset:** reset high for 2 cycles → `Tx`=1; STATUS at BASE+4 reads 32'h0000_0002.
- **Single frame (CLKS_PER_BIT=4):** store 32'hFFFF_FF55 to 0x80 → `Tx` sequence (4 cycles each) is 0,1,0,1,0,1,0,1,0,1; then STATUS returns to 32'h2 after 40+1 cycles.
- **Back-to-back:** store 0x41, 0x42 on consecutive cycles → two contiguous 40-cycle frames with no high gap between the stop bit and the second start bit; count reads 1 during the first frame.
- **Overflow (DEPTH=4):** 6 stores on consecutive cycles:
  - First byte pops at edge 2, bytes 2–5 fill the FIFO, 6th is dropped.
  - STATUS reads full=1, overflow=1, count=4.
  - Store 32'h4 to 0x84 → overflow=0.
  - Exactly 5 frames are transmitted.
- **Decode:** store to 0x88 and load from 0x7C → `Sel`=0, no enqueue, `ReadData`=0.
- **Reset mid-frame:** reset asserted during DATA bit 3 → `Tx`=1 after that edge; FIFO empty; no further frame.
